// File: rtl/mux_nin_1out_rr.sv
// N-channel to one registered output mux with valid/ready flow control.
// Fixed-select or round-robin arbitration; output stage is a single register.
module mux_nin_1out_rr #(
  parameter int unsigned LENGTH = 32,
  parameter int unsigned N      = 4,
  parameter int unsigned SEL_W  = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N*LENGTH-1:0]   in_data,
  input  logic [N-1:0]          in_valid,
  output logic [N-1:0]          in_ready,
  output logic [LENGTH-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_chan
);

  logic [LENGTH-1:0] out_data_q;
  logic              out_valid_q;
  logic [SEL_W-1:0]  out_chan_q;
  logic [SEL_W-1:0]  rr_ptr_q;

  logic              grant_found;
  logic [SEL_W-1:0]  grant_idx;
  logic [LENGTH-1:0] grant_data;
  logic              space;
  logic              accept;
  logic [SEL_W:0]    cand;

  assign space  = !out_valid_q || out_ready;
  assign accept = grant_found && enable && space && !rst;

  // Grant search. The candidate index carries one extra bit so the wrap past N-1 can be
  // handled explicitly for channel counts that are not a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (mode) begin
      for (int unsigned i = 1; i <= N; i++) begin
        cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
        if (cand >= (SEL_W+1)'(N)) begin
          cand = cand - (SEL_W+1)'(N);
        end
        if (!grant_found && in_valid[cand[SEL_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[SEL_W-1:0];
        end
      end
    end else begin
      if (({1'b0, sel} < (SEL_W+1)'(N)) && in_valid[sel]) begin
        grant_found = 1'b1;
        grant_idx   = sel;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_data = in_data[k*LENGTH +: LENGTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      in_ready[k] = accept && (grant_idx == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      rr_ptr_q    <= SEL_W'(N - 1);
    end else if (accept) begin
      out_data_q  <= grant_data;
      out_chan_q  <= grant_idx;
      out_valid_q <= 1'b1;
      if (mode) begin
        rr_ptr_q <= grant_idx;
      end
    end else if (out_ready) begin
      // Drain without refill: data and channel hold their last value.
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nin_1out_rr.sv
// Directed bench for mux_nin_1out_rr: a 4x32 instance for the main scenarios and a 5x8
// instance for out-of-range select and non-power-of-two round-robin wrap.
module tb_mux_nin_1out_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable, mode, out_ready, out_valid;
  logic [1:0]  sel, out_chan;
  logic [127:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [31:0] out_data;

  logic        enable5, mode5, out_ready5, out_valid5;
  logic [2:0]  sel5, out_chan5;
  logic [39:0] in_data5;
  logic [4:0]  in_valid5, in_ready5;
  logic [7:0]  out_data5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_nin_1out_rr #(.LENGTH(32), .N(4)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
  );

  mux_nin_1out_rr #(.LENGTH(8), .N(5)) u_dut5 (
    .clk(clk), .rst(rst), .enable(enable5), .mode(mode5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5), .out_chan(out_chan5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b1; mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
    in_data = {32'd4, 32'd3, 32'd2, 32'd1}; in_valid = 4'b1111;
    enable5 = 1'b0; mode5 = 1'b0; sel5 = 3'd0; out_ready5 = 1'b1;
    in_data5 = {8'h15, 8'h14, 8'h13, 8'h12, 8'h11}; in_valid5 = 5'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan got %0d want 0", out_chan); end
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready got %b want 0010", in_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd2 || out_chan !== 2'd1) begin
        errors++;
        $display("FAIL fixed_out cyc %0d got v=%b d=%h c=%0d want v=1 d=2 c=1", i, out_valid, out_data, out_chan);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_ready = 4'b0001 << (i % 4);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rr_ready cyc %0d got %b want %b", i, in_ready, exp_ready); end
      step();
      checks++;
      if (out_chan !== 2'(i % 4) || out_data !== 32'(i % 4 + 1) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_out cyc %0d got c=%0d d=%h want c=%0d d=%0d", i, out_chan, out_data, i % 4, i % 4 + 1);
      end
    end
  endtask

  task automatic test_rr_skip();
    logic [1:0] exp_chan;
    logic [3:0] exp_ready;
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_chan  = (i % 2 == 0) ? 2'd1 : 2'd3;
      exp_ready = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL skip_ready cyc %0d got %b want %b", i, in_ready, exp_ready); end
      step();
      checks++;
      if (out_chan !== exp_chan || out_data !== 32'(exp_chan) + 32'd1) begin
        errors++;
        $display("FAIL skip_out cyc %0d got c=%0d d=%h want c=%0d", i, out_chan, out_data, exp_chan);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL bp_ready got %b want 0000", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h3 || out_chan !== 2'd2 || in_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b d=%h c=%0d r=%b want v=1 d=3 c=2 r=0000",
                 i, out_valid, out_data, out_chan, in_ready);
      end
    end
    out_ready = 1'b1; sel = 2'd0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready got %b want 0001", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1 || out_chan !== 2'd0) begin
      errors++; $display("FAIL bp_next got v=%b d=%h c=%0d want v=1 d=1 c=0", out_valid, out_data, out_chan);
    end
    in_valid = 4'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h1 || out_chan !== 2'd0) begin
      errors++; $display("FAIL bp_drain got v=%b d=%h c=%0d want v=0 d=1 c=0", out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_enable();
    in_valid = 4'b1111; sel = 2'd1; out_ready = 1'b0; enable = 1'b1;
    step();
    enable = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL en_ready_held got %b want 0000", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h2 || out_chan !== 2'd1) begin
      errors++; $display("FAIL en_hold got v=%b d=%h c=%0d want v=1 d=2 c=1", out_valid, out_data, out_chan);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL en_ready_space got %b want 0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_drain got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h2) begin errors++; $display("FAIL en_idle got v=%b d=%h want v=0 d=2", out_valid, out_data); end
    enable = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL en_resume_ready got %b want 0010", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h2) begin errors++; $display("FAIL en_resume got v=%b d=%h want v=1 d=2", out_valid, out_data); end
  endtask

  task automatic test_sel_out_of_range();
    enable5 = 1'b1; mode5 = 1'b0; out_ready5 = 1'b1; in_valid5 = 5'b11111; sel5 = 3'b101;
    #1;
    checks++; if (in_ready5 !== 5'b0) begin errors++; $display("FAIL sel5_ready got %b want 00000", in_ready5); end
    step();
    checks++; if (out_valid5 !== 1'b0) begin errors++; $display("FAIL sel5_novalid got %b want 0", out_valid5); end
    sel5 = 3'b111;
    #1;
    checks++; if (in_ready5 !== 5'b0) begin errors++; $display("FAIL sel7_ready got %b want 00000", in_ready5); end
    sel5 = 3'b100;
    #1;
    checks++; if (in_ready5 !== 5'b10000) begin errors++; $display("FAIL sel4_ready got %b want 10000", in_ready5); end
    step();
    checks++;
    if (out_valid5 !== 1'b1 || out_data5 !== 8'h15 || out_chan5 !== 3'd4) begin
      errors++; $display("FAIL sel4_out got v=%b d=%h c=%0d want v=1 d=15 c=4", out_valid5, out_data5, out_chan5);
    end
  endtask

  task automatic test_rr_wrap5();
    logic [2:0] exp_chan;
    mode5 = 1'b1; in_valid5 = 5'b10001;
    for (int i = 0; i < 3; i++) begin
      exp_chan = (i == 1) ? 3'd4 : 3'd0;
      step();
      checks++;
      if (out_chan5 !== exp_chan || out_data5 !== 8'h11 + 8'(exp_chan)) begin
        errors++; $display("FAIL wrap5 cyc %0d got c=%0d d=%h want c=%0d", i, out_chan5, out_data5, exp_chan);
      end
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; in_valid = 4'b1111; enable = 1'b1; out_ready = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got %b want 1", out_valid); end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_chan !== 2'd0 || in_ready !== 4'b0) begin
      errors++; $display("FAIL ar_now got v=%b d=%h c=%0d r=%b want all 0", out_valid, out_data, out_chan, in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL ar_first_ready got %b want 0001", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 32'd1) begin
      errors++; $display("FAIL ar_first got v=%b c=%0d d=%h want v=1 c=0 d=1", out_valid, out_chan, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_rr_skip();
    test_backpressure();
    test_enable();
    test_sel_out_of_range();
    test_rr_wrap5();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
